// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares one 8-digit multiplexed 7-segment display among
// three requesters (clock, stopwatch, scroller) with fixed priority, a minimum
// hold time before preemption, a one-frame blank between owners, and
// frame-synchronous data latching so a frame never shows mixed data.
//
// Ports:
//   clk              system clock, all state on its rising edge
//   rst              asynchronous active-low reset
//   req[2:0]         display requests, bit0 highest priority
//   data0..data2     8 x 4-bit digit codes per requester, digit i = [4i+3:4i]
//   gnt[2:0]         one-hot grant of current owner, zero when none
//   an[7:0]          active-low anode select, digit i drives an[i]
//   cn[7:0]          active-low segment pattern, bit0 = decimal point
//   frame            one-clk pulse on every frame-boundary tick
module seg_display_arbiter #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter int unsigned MIN_HOLD = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  req,
    input  logic [31:0] data0,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic [2:0]  gnt,
    output logic [7:0]  an,
    output logic [7:0]  cn,
    output logic        frame
);

    localparam int unsigned PRESC_W = 20;
    localparam int unsigned HOLD_W  = 8;
    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_MIN  = HOLD_W'(MIN_HOLD - 1);
    localparam logic [HOLD_W-1:0]  HOLD_SAT  = 8'hFF;
    localparam logic [31:0]        BUF_RST   = 32'hAAAA_AAAA;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [PRESC_W-1:0]   presc, presc_d;
    logic [2:0]           digit, digit_d;
    logic [HOLD_W-1:0]    hold, hold_d;
    logic [31:0]          fbuf, fbuf_d;
    logic [2:0]           gnt_d;
    logic [7:0]           an_d, cn_d;
    logic                 frame_d;

    logic                 tick_c;
    logic                 boundary_c;
    logic [2:0]           pick_c;
    logic [2:0]           src_c;
    logic [31:0]          src_data_c;
    logic                 owner_req_c;
    logic                 higher_req_c;

    // 4-bit digit code to active-low segments; codes 10..15 are blank
    function automatic logic [7:0] seg_decode(input logic [3:0] code);
        case (code)
            4'd0:    return 8'h03;
            4'd1:    return 8'h9F;
            4'd2:    return 8'h25;
            4'd3:    return 8'h0D;
            4'd4:    return 8'h99;
            4'd5:    return 8'h49;
            4'd6:    return 8'h41;
            4'd7:    return 8'h1B;
            4'd8:    return 8'h01;
            4'd9:    return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    // Fixed priority: lowest set bit wins
    function automatic logic [2:0] pick_first(input logic [2:0] r);
        if (r[0])      return 3'b001;
        else if (r[1]) return 3'b010;
        else if (r[2]) return 3'b100;
        else           return 3'b000;
    endfunction

    assign tick_c     = (presc == PRESC_MAX);
    assign boundary_c = tick_c && (digit == 3'd7);
    assign pick_c     = pick_first(req);

    // Data source: current owner while active, otherwise the new winner
    assign src_c = (state == ACTIVE) ? gnt : pick_c;

    always_comb begin
        case (src_c)
            3'b010:  src_data_c = data1;
            3'b100:  src_data_c = data2;
            default: src_data_c = data0;
        endcase
    end

    // gnt - 1 on a one-hot grant masks exactly the higher-priority bits
    assign owner_req_c  = |(req & gnt);
    assign higher_req_c = |(req & (gnt - 3'd1));

    // Next-state and registered-output logic
    always_comb begin
        state_d = state;
        presc_d = presc + PRESC_W'(1);
        digit_d = digit;
        hold_d  = hold;
        fbuf_d  = fbuf;
        gnt_d   = gnt;
        an_d    = an;
        cn_d    = cn;
        frame_d = 1'b0;

        if (tick_c) begin
            presc_d = '0;
            digit_d = digit + 3'd1;

            if (boundary_c) begin
                frame_d = 1'b1;
                case (state)
                    ACTIVE: begin
                        if (!owner_req_c || (higher_req_c && (hold >= HOLD_MIN))) begin
                            gnt_d   = 3'b000;
                            state_d = BLANK;
                        end else begin
                            fbuf_d = src_data_c;
                            if (hold != HOLD_SAT) begin
                                hold_d = hold + HOLD_W'(1);
                            end
                        end
                    end
                    default: begin
                        // IDLE and BLANK both re-arbitrate on current requests
                        if (|req) begin
                            gnt_d   = pick_c;
                            fbuf_d  = src_data_c;
                            hold_d  = '0;
                            state_d = ACTIVE;
                        end else begin
                            gnt_d   = 3'b000;
                            state_d = IDLE;
                        end
                    end
                endcase
            end

            // Outputs follow the post-tick state and frame buffer
            if (state_d == ACTIVE) begin
                an_d = ~(8'h01 << digit_d);
                cn_d = seg_decode(fbuf_d[{digit_d, 2'b00} +: 4]);
            end else begin
                an_d = 8'hFF;
                cn_d = 8'hFF;
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            presc <= '0;
            digit <= '0;
            hold  <= '0;
            fbuf  <= BUF_RST;
            gnt   <= 3'b000;
            an    <= 8'hFF;
            cn    <= 8'hFF;
            frame <= 1'b0;
        end else begin
            state <= state_d;
            presc <= presc_d;
            digit <= digit_d;
            hold  <= hold_d;
            fbuf  <= fbuf_d;
            gnt   <= gnt_d;
            an    <= an_d;
            cn    <= cn_d;
            frame <= frame_d;
        end
    end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Testbench for seg_display_arbiter (SCAN_DIV=4, MIN_HOLD=2).
// A frame-level reference model predicts an/cn/gnt/frame at every scan tick
// and queues it; a monitor checks every cycle against the queue (on ticks)
// or against the held value (between ticks).
module tb_seg_display_arbiter;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned MIN_HOLD = 2;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] cn;
        logic [2:0] gnt;
        logic       frame;
    } obs_t;

    localparam obs_t RST_OBS = {8'hFF, 8'hFF, 3'b000, 1'b0};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [31:0] data0 = 32'h7654_3210;
    logic [31:0] data1 = 32'h8901_2345;
    logic [31:0] data2 = 32'h5F5A_C9E1;
    logic [2:0]  gnt;
    logic [7:0]  an;
    logic [7:0]  cn;
    logic        frame;

    int n_cmp = 0;
    int n_err = 0;

    obs_t exp_q[$];

    logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1B,
                                 8'h01, 8'h09, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    // Model state: owner index (-1 = nothing shown), frames held, shown data
    int          m_cyc   = 0;
    int          m_owner = -1;
    int          m_held  = 0;
    int          m_digit = 0;
    logic [31:0] m_shown = 32'hAAAA_AAAA;

    seg_display_arbiter #(
        .SCAN_DIV (SCAN_DIV),
        .MIN_HOLD (MIN_HOLD)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data0 (data0),
        .data1 (data1),
        .data2 (data2),
        .gnt   (gnt),
        .an    (an),
        .cn    (cn),
        .frame (frame)
    );

    always #5 clk = ~clk;

    function automatic int lowest_req(input logic [2:0] r);
        for (int i = 0; i < 3; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [31:0] word_of(input int idx);
        if (idx == 1) return data1;
        if (idx == 2) return data2;
        return data0;
    endfunction

    // Reference model: every SCAN_DIV clocks is a tick, every 8th tick a frame boundary
    initial begin
        obs_t e;
        int   t;
        forever begin
            @(posedge clk);
            if (!rst) begin
                m_cyc   = 0;
                m_owner = -1;
                m_held  = 0;
                m_digit = 0;
                exp_q.delete();
            end else begin
                m_cyc++;
                if (m_cyc % SCAN_DIV == 0) begin
                    t       = m_cyc / SCAN_DIV;
                    m_digit = t % 8;
                    if (m_digit == 0) begin
                        if (m_owner < 0) begin
                            // idle or after a blank frame: grant the winner, if any
                            m_owner = lowest_req(req);
                            if (m_owner >= 0) begin
                                m_held  = 0;
                                m_shown = word_of(m_owner);
                            end
                        end else if (!req[m_owner]) begin
                            m_owner = -1;
                        end else if (lowest_req(req) < m_owner && m_held >= MIN_HOLD - 1) begin
                            m_owner = -1;
                        end else begin
                            m_shown = word_of(m_owner);
                            if (m_held < 255) m_held++;
                        end
                    end
                    if (m_owner >= 0) begin
                        e.gnt = 3'(1 << m_owner);
                        e.an  = 8'hFF ^ (8'h01 << m_digit);
                        e.cn  = seg_tab[m_shown[m_digit*4 +: 4]];
                    end else begin
                        e.gnt = 3'b000;
                        e.an  = 8'hFF;
                        e.cn  = 8'hFF;
                    end
                    e.frame = (m_digit == 0);
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Monitor: sample on the falling edge, away from the active edge
    initial begin
        obs_t held;
        obs_t want;
        obs_t got;
        held = RST_OBS;
        forever begin
            @(negedge clk);
            got = {an, cn, gnt, frame};
            if (!rst) begin
                exp_q.delete();
                held = RST_OBS;
                want = RST_OBS;
            end else if (exp_q.size() > 0) begin
                want       = exp_q.pop_front();
                held       = want;
                held.frame = 1'b0;
            end else begin
                want = held;
            end
            n_cmp++;
            if (got !== want) begin
                n_err++;
                $display("FAIL outputs t=%0t an=%h/%h cn=%h/%h gnt=%b/%b frame=%b/%b (got/expected)",
                         $time, got.an, want.an, got.cn, want.cn, got.gnt, want.gnt,
                         got.frame, want.frame);
            end
        end
    end

    // Inputs change 2 time units after the rising edge
    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    initial begin
        bit found;
        int r;

        // reset held for a few cycles, then released
        step(3);
        rst = 1'b1;

        // scan with clock as sole requester
        req = 3'b001;
        step(32 * 3);

        // idle display
        req = 3'b000;
        step(32 * 3);

        // scroller owns, clock requests and preempts after the hold time
        req = 3'b100;
        step(32 * 2);
        req = 3'b101;
        step(32 * 5);

        // lower-priority requests never preempt
        req = 3'b001;
        step(32 * 2);
        req = 3'b111;
        step(32 * 10);

        // stopwatch owns; its data changes mid-frame
        req = 3'b010;
        step(32 * 3 + 13);
        data1 = 32'h1357_9246;
        step(32 * 2);
        data1 = 32'h0000_00FB;
        step(7);
        req = 3'b110;
        step(32 * 2);

        // asynchronous reset while displaying digit 5
        req   = 3'b001;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step(1);
            if (m_owner >= 0 && m_digit == 5 && (m_cyc % SCAN_DIV) == 0) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL reset_setup never reached digit 5 while active");
        end
        #1 rst = 1'b0;
        #1;
        n_cmp++;
        if ({an, cn, gnt, frame} !== RST_OBS) begin
            n_err++;
            $display("FAIL async_reset an=%h cn=%h gnt=%b frame=%b required ff ff 000 0",
                     an, cn, gnt, frame);
        end
        step(4);
        rst = 1'b1;
        req = 3'b010;
        step(32 * 3);

        // randomized requests and data
        for (int i = 0; i < 2500; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3) req = 3'($urandom_range(0, 7));
            r = int'($urandom_range(0, 99));
            if (r < 6) begin
                case ($urandom_range(0, 2))
                    0:       data0 = $urandom;
                    1:       data1 = $urandom;
                    default: data2 = $urandom;
                endcase
            end
            step(1);
        end

        step(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
